// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - Execute stage: single-cycle ALU plus 32-cycle shift-add multiplier
//
// Purpose: computes the EX result for one instruction. Most ops take one
// cycle from valid_in to valid_out. MUL runs an iterative shift-add and holds
// stall_out high for the 32 cycles it is busy.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   valid_in                    operands below are valid this cycle
//   data_1_in, data_2_in        operand A (rs1) and rs2 value
//   Rd_in                       destination register
//   ALU_ctrl_in                 operation select
//   ALU_src_in, imm_in          operand B = imm_in when ALU_src_in=1, else data_2_in
//   ALU_result_out, data_2_out  registered result and store data
//   Rd_out, zero_out            registered destination and result==0 flag
//   valid_out                   outputs carry a new result this cycle
//   stall_out                   stage busy; upstream must hold its inputs
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] data_1_in,
  input  logic [31:0] data_2_in,
  input  logic [4:0]  Rd_in,
  input  logic [3:0]  ALU_ctrl_in,
  input  logic        ALU_src_in,
  input  logic [31:0] imm_in,
  output logic [31:0] ALU_result_out,
  output logic [31:0] data_2_out,
  output logic [4:0]  Rd_out,
  output logic        zero_out,
  output logic        valid_out,
  output logic        stall_out
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic [4:0]  mul_rd_q, mul_rd_d;
  logic [31:0] mul_d2_q, mul_d2_d;
  logic [31:0] result_q, result_d;
  logic [31:0] d2_out_q, d2_out_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        zero_q, zero_d;
  logic        valid_q, valid_d;

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic [31:0] acc_next;

  assign op_b  = ALU_src_in ? imm_in : data_2_in;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (ALU_ctrl_in)
      OP_AND:  alu_res = data_1_in & op_b;
      OP_OR:   alu_res = data_1_in | op_b;
      OP_ADD:  alu_res = data_1_in + op_b;
      OP_XOR:  alu_res = data_1_in ^ op_b;
      OP_SLL:  alu_res = data_1_in << shamt;
      OP_SRL:  alu_res = data_1_in >> shamt;
      OP_SUB:  alu_res = data_1_in - op_b;
      OP_SLT:  alu_res = ($signed(data_1_in) < $signed(op_b)) ? 32'd1 : 32'd0;
      OP_SRA:  alu_res = $unsigned($signed(data_1_in) >>> shamt);
      OP_SLTU: alu_res = (data_1_in < op_b) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  // One partial product per cycle; only the low 32 bits are kept, so the
  // product is the same for signed and unsigned operands.
  assign acc_next = acc_q + (mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : 32'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    mul_rd_d = mul_rd_q;
    mul_d2_d = mul_d2_q;
    result_d = result_q;
    d2_out_d = d2_out_q;
    rd_out_d = rd_out_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (ALU_ctrl_in == OP_MUL) begin
            mul_a_d  = data_1_in;
            mul_b_d  = op_b;
            mul_rd_d = Rd_in;
            mul_d2_d = data_2_in;
            cnt_d    = 5'd0;
            acc_d    = 32'd0;
            state_d  = S_MUL_BUSY;
          end else begin
            result_d = alu_res;
            d2_out_d = data_2_in;
            rd_out_d = Rd_in;
            zero_d   = (alu_res == 32'd0);
            valid_d  = 1'b1;
          end
        end
      end
      S_MUL_BUSY: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = acc_next;
          d2_out_d = mul_d2_q;
          rd_out_d = mul_rd_q;
          zero_d   = (acc_next == 32'd0);
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 32'd0;
      mul_a_q  <= 32'd0;
      mul_b_q  <= 32'd0;
      mul_rd_q <= 5'd0;
      mul_d2_q <= 32'd0;
      result_q <= 32'd0;
      d2_out_q <= 32'd0;
      rd_out_q <= 5'd0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      mul_rd_q <= mul_rd_d;
      mul_d2_q <= mul_d2_d;
      result_q <= result_d;
      d2_out_q <= d2_out_d;
      rd_out_q <= rd_out_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign ALU_result_out = result_q;
  assign data_2_out     = d2_out_q;
  assign Rd_out         = rd_out_q;
  assign zero_out       = zero_q;
  assign valid_out      = valid_q;
  assign stall_out      = (state_q == S_MUL_BUSY);

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL expose ports, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- valid_in  in  1  operands from ID/EX register are valid
- data_1_in  in  32  operand A (rs1 value)
- data_2_in  in  32  rs2 value
- Rd_in  in  5  destination register
- ALU_ctrl_in  in  4  operation select
- ALU_src_in  in  1  1 = operand B is imm_in, 0 = operand B is data_2_in
- imm_in  in  32  sign-extended immediate
- ALU_result_out  out  32  registered result (EX/MEM)
- data_2_out  out  32  registered rs2 value (store data)
- Rd_out  out  5  registered destination
- zero_out  out  1  registered (ALU_result == 0)
- valid_out  out  1  outputs hold a new result this cycle
- stall_out  out  1  stage busy; upstream SHALL hold its inputs

Function
REQ-003 Operand B SHALL be imm_in when ALU_src_in=1, else data_2_in.
REQ-004 ALU_ctrl_in encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SRA, 1001 SLTU, 1010 MUL (low 32 bits); all other codes SHALL produce result 0.
REQ-005 ADD/SUB SHALL wrap modulo 2^32 with no overflow flag; shift amount SHALL be B[4:0]; SLT/SLTU SHALL produce 32'd1 or 32'd0.
REQ-006 SHALL implement a two-state FSM: IDLE and MUL_BUSY.
REQ-007 In IDLE with valid_in=1 and a non-MUL op, the rising edge SHALL register ALU_result_out, data_2_out, Rd_out, zero_out and set valid_out=1 (1-cycle latency).
REQ-008 In IDLE with valid_in=0, valid_out SHALL be 0 after the edge; the data outputs SHALL hold their previous values.
REQ-009 In IDLE with valid_in=1 and op MUL, the edge (E0) SHALL latch A, B, Rd_in and data_2_in, clear the product accumulator and a 5-bit counter, enter MUL_BUSY, and set valid_out=0.
REQ-010 MUL_BUSY SHALL perform one shift-add step per cycle (add A<<k when B[k]=1, k = counter).
- At the 32nd edge after E0 (counter=31), the product low 32 bits SHALL be registered to ALU_result_out.
- Latched Rd and data_2 SHALL be registered to Rd_out and data_2_out.
- zero_out SHALL update, valid_out SHALL be 1 for one cycle, and the FSM SHALL return to IDLE.
REQ-011 stall_out SHALL be combinational and equal to 1 exactly while the state is MUL_BUSY (32 cycles per MUL); 0 otherwise.
REQ-012 While in MUL_BUSY, valid_in and all operand inputs SHALL be ignored; valid_out SHALL be 0.
REQ-013 A non-MUL op presented in the cycle after the MUL result edge SHALL be accepted normally (back-to-back allowed).
REQ-014 MUL results SHALL be identical for signed and unsigned interpretation (low 32 bits only); overflow SHALL be discarded.

Reset
REQ-015 Assertion of reset SHALL immediately (asynchronously) force:
- ALU_result_out=0, data_2_out=0, Rd_out=0, zero_out=0, valid_out=0
- state=IDLE, counter=0, accumulator=0, hence stall_out=0
REQ-016 Reset during MUL_BUSY SHALL abandon the multiply with no valid_out pulse.
REQ-017 After deassertion, the first rising edge with valid_in=1 SHALL be accepted.

Verification
REQ-018 ADD: A=5, imm=0xFFFFFFFD, ALU_src=1, Rd=7 -> next cycle ALU_result_out=2, Rd_out=7, valid_out=1, zero_out=0.
REQ-019 SUB: A=B=0x1234 -> ALU_result_out=0, zero_out=1; then SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0.
REQ-020 MUL: A=0xFFFFFFFF, B=3 -> stall_out=1 for 32 cycles; then ALU_result_out=0xFFFFFFFD, valid_out=1 for one cycle; inputs changed during busy have no effect.
REQ-021 Shifts: A=0x80000000, B=4 -> SRL 0x08000000, SRA 0xF8000000, SLL 0x00000000 with zero_out=1.
REQ-022 Reset asserted mid-MUL (counter=10) -> all outputs 0 immediately, stall_out=0; after release, ADD 1+1 -> 2 next cycle.
REQ-023 Back-to-back: ADD, MUL 6*7, ADD every cycle (held while stalled) -> results 1 cycle, 32 cycles later 42, then next ADD 1 cycle later; valid_out pulses exactly three times.
